// File: rtl/psk_symbol_modulator.sv
`default_nettype none
// ============================================================================
// Module      : psk_symbol_modulator
// Description : BPSK/QPSK symbol mapper with rectangular SPS-sample hold,
//               alternating preamble and zero tail symbol per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module psk_symbol_modulator #(
    parameter int WIDTH        = 16,
    parameter int SPS          = 32,
    parameter int AMPLITUDE    = 8192,
    parameter int PREAMBLE_LEN = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    is_bpsk,
    input  logic [1:0]              data_bits,
    input  logic                    data_valid,
    input  logic                    data_last,
    output logic                    data_ready,
    output logic signed [WIDTH-1:0] I,
    output logic signed [WIDTH-1:0] Q,
    output logic                    sym_strobe,
    output logic                    underrun,
    output logic                    busy
);

    localparam int CNT_W = $clog2(SPS);
    localparam int PRE_W = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
    localparam logic [CNT_W-1:0]        c_CNT_LAST = CNT_W'(SPS - 1);
    localparam logic [PRE_W-1:0]        c_PRE_LAST = PRE_W'(PREAMBLE_LEN - 1);
    localparam logic signed [WIDTH-1:0] c_POS      = WIDTH'(AMPLITUDE);
    localparam logic signed [WIDTH-1:0] c_NEG      = -c_POS;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_DATA = 3'd2,
        S_LAST = 3'd3,
        S_TAIL = 3'd4
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
    logic [PRE_W-1:0]          r_pre_idx, w_pre_nxt;
    logic                      r_bpsk, w_bpsk_nxt;
    logic signed [WIDTH-1:0]   r_i, w_i_nxt;
    logic signed [WIDTH-1:0]   r_q, w_q_nxt;
    logic                      r_strobe, w_strobe_nxt;
    logic                      r_underrun, w_underrun_nxt;

    logic                      w_boundary;
    logic                      w_last_pre;
    logic signed [WIDTH-1:0]   w_map_i;
    logic signed [WIDTH-1:0]   w_map_q;
    logic signed [WIDTH-1:0]   w_pre_lvl;

    assign w_boundary = (r_cnt == c_CNT_LAST);
    assign w_last_pre = (r_pre_idx == c_PRE_LAST);
    assign data_ready = w_boundary &&
                        ((r_state == S_DATA) || ((r_state == S_PRE) && w_last_pre));
    assign busy       = (r_state != S_IDLE);

    // Bit 0 maps to +A, bit 1 to -A, matching the receiver's sign-bit slicer.
    assign w_map_i   = (r_bpsk ? data_bits[0] : data_bits[1]) ? c_NEG : c_POS;
    assign w_map_q   = r_bpsk ? '0 : (data_bits[0] ? c_NEG : c_POS);
    // Level of the NEXT preamble symbol: even index +A, odd index -A.
    assign w_pre_lvl = r_pre_idx[0] ? c_POS : c_NEG;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt + 1'b1;
        w_pre_nxt      = r_pre_idx;
        w_bpsk_nxt     = r_bpsk;
        w_i_nxt        = r_i;
        w_q_nxt        = r_q;
        w_strobe_nxt   = 1'b0;
        w_underrun_nxt = 1'b0;

        if (r_state == S_IDLE) begin
            w_cnt_nxt = '0;
            w_i_nxt   = '0;
            w_q_nxt   = '0;
            if (start) begin
                w_state_nxt  = S_PRE;
                w_pre_nxt    = '0;
                w_bpsk_nxt   = is_bpsk;
                w_i_nxt      = c_POS;
                w_q_nxt      = is_bpsk ? '0 : c_POS;
                w_strobe_nxt = 1'b1;
            end
        end else if (w_boundary) begin
            w_cnt_nxt    = '0;
            w_strobe_nxt = 1'b1;
            if (data_ready) begin
                if (data_valid) begin
                    w_i_nxt     = w_map_i;
                    w_q_nxt     = w_map_q;
                    w_state_nxt = data_last ? S_LAST : S_DATA;
                end else begin
                    // Starved boundary: emit a zero symbol and stay in DATA.
                    w_i_nxt        = '0;
                    w_q_nxt        = '0;
                    w_underrun_nxt = 1'b1;
                    w_state_nxt    = S_DATA;
                end
            end else begin
                case (r_state)
                    S_PRE: begin
                        w_pre_nxt = r_pre_idx + 1'b1;
                        w_i_nxt   = w_pre_lvl;
                        w_q_nxt   = r_bpsk ? '0 : w_pre_lvl;
                    end
                    S_LAST: begin
                        w_state_nxt = S_TAIL;
                        w_i_nxt     = '0;
                        w_q_nxt     = '0;
                    end
                    S_TAIL: begin
                        w_state_nxt  = S_IDLE;
                        w_i_nxt      = '0;
                        w_q_nxt      = '0;
                        w_strobe_nxt = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_pre_idx  <= '0;
            r_bpsk     <= 1'b1;
            r_i        <= '0;
            r_q        <= '0;
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pre_idx  <= w_pre_nxt;
            r_bpsk     <= w_bpsk_nxt;
            r_i        <= w_i_nxt;
            r_q        <= w_q_nxt;
            r_strobe   <= w_strobe_nxt;
            r_underrun <= w_underrun_nxt;
        end
    end

    assign I          = r_i;
    assign Q          = r_q;
    assign sym_strobe = r_strobe;
    assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_psk_symbol_modulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_psk_symbol_modulator
// Description : Frame-level reference model driving directed and random frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psk_symbol_modulator;

    localparam int WIDTH = 16;
    localparam int SPS   = 32;
    localparam int AMP   = 8192;
    localparam int PLEN  = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic                    is_bpsk;
    logic [1:0]              data_bits;
    logic                    data_valid;
    logic                    data_last;
    logic                    data_ready;
    logic signed [WIDTH-1:0] I;
    logic signed [WIDTH-1:0] Q;
    logic                    sym_strobe;
    logic                    underrun;
    logic                    busy;

    psk_symbol_modulator #(
        .WIDTH       (WIDTH),
        .SPS         (SPS),
        .AMPLITUDE   (AMP),
        .PREAMBLE_LEN(PLEN)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_bpsk   (is_bpsk),
        .data_bits (data_bits),
        .data_valid(data_valid),
        .data_last (data_last),
        .data_ready(data_ready),
        .I         (I),
        .Q         (Q),
        .sym_strobe(sym_strobe),
        .underrun  (underrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Frame plan: one entry per post-preamble symbol slot.
    bit         slot_under[$];
    logic [1:0] slot_bits[$];
    bit         frame_bpsk;

    task automatic check_val(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lvl(input bit b);
        return b ? -AMP : AMP;
    endfunction

    // Expected I/Q and underrun flag for symbol s of the current frame.
    task automatic exp_sym(input int s, output int ei, output int eq, output bit eu);
        int n;
        n  = slot_under.size();
        eu = 1'b0;
        if (s < PLEN) begin
            ei = (s % 2 == 0) ? AMP : -AMP;
            eq = frame_bpsk ? 0 : ei;
        end else if (s < PLEN + n) begin
            if (slot_under[s-PLEN]) begin
                ei = 0; eq = 0; eu = 1'b1;
            end else begin
                ei = frame_bpsk ? lvl(slot_bits[s-PLEN][0]) : lvl(slot_bits[s-PLEN][1]);
                eq = frame_bpsk ? 0 : lvl(slot_bits[s-PLEN][0]);
            end
        end else begin
            ei = 0; eq = 0;
        end
    endtask

    task automatic run_frame(input bit mode, input bit noise);
        int  n, total, slot, strobes, s, ei, eq;
        bit  eu, eready;
        n       = slot_under.size();
        total   = (PLEN + n + 1) * SPS;
        slot    = 0;
        strobes = 0;
        frame_bpsk = mode;
        @(negedge clk);
        is_bpsk    = mode;
        start      = 1'b1;
        data_valid = 1'b0;
        data_last  = 1'b0;
        for (int t = 0; t < total; t++) begin
            @(negedge clk);
            s = t / SPS;
            exp_sym(s, ei, eq, eu);
            eready = (t % SPS == SPS - 1) && (s >= PLEN - 1) && (s <= PLEN + n - 2);
            check_val("I", I, ei);
            check_val("Q", Q, eq);
            check_val("sym_strobe", sym_strobe, (t % SPS == 0));
            check_val("underrun", underrun, eu && (t % SPS == 0));
            check_val("busy", busy, 1);
            check_val("data_ready", data_ready, eready);
            strobes += sym_strobe;
            if (noise) begin
                start   = ($urandom_range(0, 7) == 0);
                is_bpsk = $urandom_range(0, 1);
            end else begin
                start = 1'b0;
            end
            if (slot < n) begin
                data_valid = !slot_under[slot];
                data_bits  = slot_under[slot] ? 2'($urandom) : slot_bits[slot];
                data_last  = slot_under[slot] ? 1'($urandom) : (slot == n - 1);
            end else begin
                data_valid = 1'($urandom);
                data_bits  = 2'($urandom);
                data_last  = 1'($urandom);
            end
            if (eready) slot++;
        end
        @(negedge clk);
        start = 1'b0;
        check_val("idle_busy", busy, 0);
        check_val("idle_I", I, 0);
        check_val("idle_Q", Q, 0);
        check_val("idle_ready", data_ready, 0);
        check_val("idle_strobe", sym_strobe, 0);
        check_val("strobe_count", strobes, PLEN + n + 1);
        data_valid = 1'b0;
    endtask

    task automatic add_slot(input bit under, input logic [1:0] bits);
        slot_under.push_back(under);
        slot_bits.push_back(bits);
    endtask

    task automatic random_plan();
        int nd;
        slot_under.delete();
        slot_bits.delete();
        nd = $urandom_range(1, 6);
        for (int k = 0; k < nd; k++) begin
            if ($urandom_range(0, 3) == 0) add_slot(1'b1, 2'b00);
            add_slot(1'b0, 2'($urandom));
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        is_bpsk    = 1'b1;
        data_bits  = 2'b00;
        data_valid = 1'b0;
        data_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_I", I, 0);
        check_val("rst_Q", Q, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_strobe", sym_strobe, 0);
        check_val("rst_underrun", underrun, 0);
        rst = 1'b0;

        // BPSK bits 0,1,1
        slot_under.delete(); slot_bits.delete();
        add_slot(1'b0, 2'b00); add_slot(1'b0, 2'b01); add_slot(1'b0, 2'b11);
        run_frame(1'b1, 1'b0);

        // QPSK 2'b10 -> I=-A, Q=+A
        slot_under.delete(); slot_bits.delete();
        add_slot(1'b0, 2'b10);
        run_frame(1'b0, 1'b0);

        // Underrun between two accepted symbols
        slot_under.delete(); slot_bits.delete();
        add_slot(1'b0, 2'b01); add_slot(1'b1, 2'b00); add_slot(1'b0, 2'b11);
        run_frame(1'b0, 1'b0);

        for (int f = 0; f < 6; f++) begin
            random_plan();
            run_frame(1'($urandom), 1'b1);
        end

        // Asynchronous reset in the middle of the preamble
        @(negedge clk);
        is_bpsk = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        check_val("pre_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check_val("arst_I", I, 0);
        check_val("arst_Q", Q, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_ready", data_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_val("post_rst_busy", busy, 0);
        check_val("post_rst_I", I, 0);

        // Frame after reset starts cleanly
        random_plan();
        run_frame(1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
